// File: rtl/alu_pkg.sv
// Shared types for the ALU command driver.
// Operand/selector widths, flag positions, bundles and FSM states.
package alu_pkg;

  localparam int OPERAND_W = 4;
  localparam int SEL_W     = 3;
  localparam int ZERO_BIT  = 0;
  localparam int CARRY_BIT = 1;
  localparam int CNT_W     = 4;

  typedef struct packed {
    logic [OPERAND_W-1:0] a;
    logic [OPERAND_W-1:0] b;
    logic [SEL_W-1:0]     sel;
  } alu_cmd_t;

  typedef struct packed {
    logic [OPERAND_W-1:0] y;
    logic                 carry;
    logic                 zero;
    logic                 err;
  } alu_rsp_t;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    RESP
  } alu_drv_state_e;

  function automatic logic [7:0] pack_operands(alu_cmd_t c);
    return {c.b, c.a};
  endfunction

  function automatic logic [7:0] pack_sel(alu_cmd_t c);
    return {{(8-SEL_W){1'b0}}, c.sel};
  endfunction

  function automatic alu_rsp_t unpack_rsp(logic [7:0] uo,
                                          logic [7:0] uio);
    alu_rsp_t r;
    r.y     = uo[OPERAND_W-1:0];
    r.carry = uio[CARRY_BIT];
    r.zero  = uio[ZERO_BIT];
    r.err   = |uo[7:OPERAND_W];
    return r;
  endfunction

endpackage

// File: rtl/alu_cmd_driver.sv
// Handshaked initiator for the combinational 4-bit ALU pin interface.
// One op in flight: drive operands, wait SETTLE_CYCLES, sample, respond.
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int COUNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [3:0]         cmd_a,
  input  logic [3:0]         cmd_b,
  input  logic [2:0]         cmd_sel,
  output logic [7:0]         alu_ui_in,
  output logic [7:0]         alu_uio_in,
  input  logic [7:0]         alu_uo_out,
  input  logic [7:0]         alu_uio_out,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [3:0]         rsp_y,
  output logic               rsp_carry,
  output logic               rsp_zero,
  output logic               rsp_err,
  output logic               busy,
  output logic [COUNT_W-1:0] op_count
);

  localparam logic [CNT_W-1:0] SETTLE_INIT =
    CNT_W'(SETTLE_CYCLES - 1);

  alu_drv_state_e    state;
  alu_drv_state_e    state_next;
  logic [CNT_W-1:0]  settle_cnt;
  logic              load_cmd;
  logic              capture;
  logic              rsp_fire;
  alu_cmd_t          cmd;
  alu_rsp_t          rsp_d;
  alu_rsp_t          rsp_q;
  logic              unused_flags;

  assign cmd = '{a: cmd_a, b: cmd_b, sel: cmd_sel};
  assign rsp_d = unpack_rsp(alu_uo_out, alu_uio_out);

  // Flag bus bits above carry carry no meaning here.
  assign unused_flags = ^alu_uio_out[7:2];

  // State register; reset abandons any op in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and handshake strobes.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    load_cmd   = 1'b0;
    capture    = 1'b0;
    rsp_fire   = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          load_cmd   = 1'b1;
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == '0) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_valid && rsp_ready) begin
          rsp_fire   = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand buses hold the last accepted command until the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_ui_in  <= '0;
      alu_uio_in <= '0;
    end else if (load_cmd) begin
      alu_ui_in  <= pack_operands(cmd);
      alu_uio_in <= pack_sel(cmd);
    end
  end

  // Settle countdown: loaded on accept, counts to zero in SETTLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= '0;
    end else if (load_cmd) begin
      settle_cnt <= SETTLE_INIT;
    end else if (state == SETTLE && settle_cnt != '0) begin
      settle_cnt <= settle_cnt - CNT_W'(1);
    end
  end

  // Response capture; fields are frozen until the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_q     <= '0;
      rsp_valid <= 1'b0;
    end else if (capture) begin
      rsp_q     <= rsp_d;
      rsp_valid <= 1'b1;
    end else if (rsp_fire) begin
      rsp_valid <= 1'b0;
    end
  end

  // Completed-op counter, wraps silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= '0;
    end else if (rsp_fire) begin
      op_count <= op_count + COUNT_W'(1);
    end
  end

  assign rsp_y     = rsp_q.y;
  assign rsp_carry = rsp_q.carry;
  assign rsp_zero  = rsp_q.zero;
  assign rsp_err   = rsp_q.err;
  assign busy      = (state != IDLE);

endmodule
